// File: rtl/neosd_dat_rx.sv
// neosd_dat_rx: SD DAT0 single-block read receiver.
// Waits for the card start bit, deserialises BLOCK_BYTES of data MSB-first,
// checks CRC16-CCITT and the end bit, and hands 32-bit words to the host
// through a 2-entry registered buffer with a valid/ready handshake.
`timescale 1ns/1ps

module neosd_dat_rx #(
   parameter int BLOCK_BYTES = 512,
   parameter int TIMEOUT     = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bit_stb_i,
   input  logic        sd_dat0_i,
   input  logic        start_i,
   input  logic        abort_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   input  logic        word_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        crc_err_o,
   output logic        end_err_o,
   output logic        timeout_o,
   output logic        overrun_o
);

   localparam int NBITS = BLOCK_BYTES * 8;
   localparam int BCW   = $clog2(NBITS);
   localparam int TCW   = $clog2(TIMEOUT + 1);

   localparam logic [BCW-1:0] BLAST = BCW'(NBITS - 1);
   localparam logic [TCW-1:0] TMAX  = TCW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_DATA,
      S_CRC,
      S_END
   } state_t;

   state_t           r_state;
   logic [TCW-1:0]   r_tcnt;
   logic [BCW-1:0]   r_bcnt;
   logic [3:0]       r_ccnt;
   logic             r_done;
   logic             r_crc_err;
   logic             r_end_err;
   logic             r_timeout;
   logic             r_overrun;

   logic [31:0]      r_shift;
   logic [15:0]      r_crc;
   logic [15:0]      r_rxcrc;

   logic [31:0]      r_out;
   logic             r_out_vld;
   logic [31:0]      r_skid;
   logic             r_skid_vld;

   logic             w_start;
   logic             w_data_stb;
   logic             w_crc_stb;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_word;
   logic [TCW-1:0]   w_tcnt_nxt;

   // One serial step of CRC16-CCITT (x^16+x^12+x^5+1): feedback enters bit 0
   // and is folded into bits 5 and 12.
   function automatic logic [15:0] f_crc_next(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // A start is accepted only from IDLE and never in the same cycle as an abort.
   assign w_start    = start_i & ~abort_i & (r_state == S_IDLE);
   assign w_data_stb = bit_stb_i & (r_state == S_DATA);
   assign w_crc_stb  = bit_stb_i & (r_state == S_CRC);
   assign w_word     = {r_shift[30:0], sd_dat0_i};
   assign w_push     = w_data_stb & ~abort_i & (r_bcnt[4:0] == 5'd31);
   assign w_pop      = r_out_vld & word_ready_i;
   assign w_tcnt_nxt = r_tcnt + 1'b1;

   // Receive FSM: sequencing, counters, completion pulse and status flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_tcnt    <= '0;
         r_bcnt    <= '0;
         r_ccnt    <= '0;
         r_done    <= 1'b0;
         r_crc_err <= 1'b0;
         r_end_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort_i) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_i) begin
                     r_state   <= S_WAIT_START;
                     r_tcnt    <= '0;
                     r_bcnt    <= '0;
                     r_ccnt    <= '0;
                     r_crc_err <= 1'b0;
                     r_end_err <= 1'b0;
                     r_timeout <= 1'b0;
                  end
               end
               S_WAIT_START: begin
                  if (bit_stb_i) begin
                     if (!sd_dat0_i) begin
                        r_state <= S_DATA;
                     end else begin
                        r_tcnt <= w_tcnt_nxt;
                        if (w_tcnt_nxt == TMAX) begin
                           r_timeout <= 1'b1;
                           r_done    <= 1'b1;
                           r_state   <= S_IDLE;
                        end
                     end
                  end
               end
               S_DATA: begin
                  if (bit_stb_i) begin
                     r_bcnt <= r_bcnt + 1'b1;
                     if (r_bcnt == BLAST) begin
                        r_state <= S_CRC;
                     end
                  end
               end
               S_CRC: begin
                  if (bit_stb_i) begin
                     r_ccnt <= r_ccnt + 1'b1;
                     if (r_ccnt == 4'd15) begin
                        r_state <= S_END;
                     end
                  end
               end
               S_END: begin
                  if (bit_stb_i) begin
                     r_end_err <= ~sd_dat0_i;
                     r_crc_err <= (r_rxcrc != r_crc);
                     r_done    <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Datapath: data shift register, running CRC over data bits, received CRC.
   always_ff @(posedge clk_i) begin
      if (w_start) begin
         r_crc <= '0;
      end else if (w_data_stb) begin
         r_crc <= f_crc_next(r_crc, sd_dat0_i);
      end
      if (w_data_stb) begin
         r_shift <= w_word;
      end
      if (w_crc_stb) begin
         r_rxcrc <= {r_rxcrc[14:0], sd_dat0_i};
      end
   end

   // Two-entry word buffer: r_out drives word_o directly, r_skid holds the
   // second word; a push into a full, non-draining buffer is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (abort_i) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
      end else begin
         if (w_start) begin
            r_overrun <= 1'b0;
         end
         if (w_pop) begin
            if (r_skid_vld) begin
               r_out <= r_skid;
               if (w_push) begin
                  r_skid <= w_word;
               end else begin
                  r_skid_vld <= 1'b0;
               end
            end else if (w_push) begin
               r_out <= w_word;
            end else begin
               r_out_vld <= 1'b0;
            end
         end else if (w_push) begin
            if (!r_out_vld) begin
               r_out     <= w_word;
               r_out_vld <= 1'b1;
            end else if (!r_skid_vld) begin
               r_skid     <= w_word;
               r_skid_vld <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign word_o       = r_out;
   assign word_valid_o = r_out_vld;
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = r_done;
   assign crc_err_o    = r_crc_err;
   assign end_err_o    = r_end_err;
   assign timeout_o    = r_timeout;
   assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_neosd_dat_rx.sv
// tb_neosd_dat_rx: randomized self-checking bench for neosd_dat_rx.
// dut0 uses a 512-byte block with an 8-strobe start timeout, dut1 a 4-byte block.
`timescale 1ns/1ps

module tb_neosd_dat_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_stb = 1'b0;
   logic dat = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic abort = 1'b0;
   logic ready = 1'b0;

   logic [31:0] word0, word1;
   logic wv0, busy0, done0, crce0, ende0, to0, ov0;
   logic wv1, busy1, done1, crce1, ende1, to1, ov1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  blk[$];
   logic [31:0] expw[$];
   logic [31:0] rx0[$];
   logic [31:0] rx1[$];
   int          dn0 = 0;
   logic [3:0]  fl0 = 4'd0;

   always #5 clk = ~clk;

   neosd_dat_rx #(.BLOCK_BYTES(512), .TIMEOUT(8)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .bit_stb_i(bit_stb), .sd_dat0_i(dat),
      .start_i(start0), .abort_i(abort), .word_o(word0), .word_valid_o(wv0),
      .word_ready_i(ready), .busy_o(busy0), .done_o(done0), .crc_err_o(crce0),
      .end_err_o(ende0), .timeout_o(to0), .overrun_o(ov0)
   );

   neosd_dat_rx #(.BLOCK_BYTES(4), .TIMEOUT(1024)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .bit_stb_i(bit_stb), .sd_dat0_i(dat),
      .start_i(start1), .abort_i(abort), .word_o(word1), .word_valid_o(wv1),
      .word_ready_i(ready), .busy_o(busy1), .done_o(done1), .crc_err_o(crce1),
      .end_err_o(ende1), .timeout_o(to1), .overrun_o(ov1)
   );

   // Consumer side: record every accepted word and every done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (wv0 && ready) rx0.push_back(word0);
         if (wv1 && ready) rx1.push_back(word1);
         if (done0) begin
            dn0++;
            fl0 = {crce0, ende0, to0, ov0};
         end
      end
   end

   // Reference: CRC16-CCITT over the whole block, bit by bit, MSB first.
   function automatic logic [15:0] model_crc();
      logic [15:0] c;
      logic [7:0]  b;
      logic        fb;
      c = 16'h0000;
      foreach (blk[k]) begin
         b = blk[k];
         for (int j = 7; j >= 0; j--) begin
            fb = c[15] ^ b[j];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // Reference: group wire bytes into big-endian words.
   task automatic build_exp();
      expw.delete();
      for (int k = 0; k < blk.size() / 4; k++)
         expw.push_back({blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]});
   endtask

   task automatic fill_rand(input int n);
      blk.delete();
      repeat (n) blk.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic strobe(input logic b);
      dat = b;
      bit_stb = 1'b1;
      @(posedge clk); #1;
      bit_stb = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk); #1;
      ready = v;
   endtask

   task automatic arm(input int d);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] c, input logic eb, input int idle);
      logic [7:0] b;
      for (int i = 0; i < idle; i++) begin strobe(1'b1); gap(); end
      strobe(1'b0); gap();
      foreach (blk[k]) begin
         b = blk[k];
         for (int j = 7; j >= 0; j--) begin strobe(b[j]); gap(); end
      end
      for (int j = 15; j >= 0; j--) begin strobe(c[j]); gap(); end
      strobe(eb); gap();
      dat = 1'b1;
   endtask

   // Count received words differing from the model (size mismatch counts too).
   function automatic int word_diffs(input logic [31:0] got[$]);
      int nb;
      nb = (got.size() != expw.size()) ? 1 : 0;
      for (int i = 0; i < got.size() && i < expw.size(); i++)
         if (got[i] !== expw[i]) nb++;
      return nb;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({word0, wv0, busy0, done0, crce0, ende0, to0, ov0} !== 39'd0) begin
         n_err++;
         $display("FAIL reset_dut0: got %h required 0", {word0, wv0, busy0, done0, crce0, ende0, to0, ov0});
      end
      n_cmp++;
      if ({word1, wv1, busy1, done1, crce1, ende1, to1, ov1} !== 39'd0) begin
         n_err++;
         $display("FAIL reset_dut1: got %h required 0", {word1, wv1, busy1, done1, crce1, ende1, to1, ov1});
      end
   endtask

   // 512 x 0xFF with good CRC, corrupted CRC, and bad end bit.
   task automatic test_ff_block();
      logic [15:0] crcs[3] = '{16'h7FA1, 16'h7FA0, 16'h7FA1};
      logic        ends[3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0]  efl[3]  = '{4'b0000, 4'b1000, 4'b0100};
      int d, nb;
      blk.delete();
      repeat (512) blk.push_back(8'hFF);
      build_exp();
      for (int t = 0; t < 3; t++) begin
         set_ready(1'b1);
         rx0.delete();
         d = dn0;
         arm(0);
         send_frame(crcs[t], ends[t], $urandom_range(0, 6));
         repeat (4) @(negedge clk);
         n_cmp++;
         if (dn0 - d !== 1) begin
            n_err++;
            $display("FAIL ff_done_count[%0d]: got %0d required 1", t, dn0 - d);
         end
         n_cmp++;
         if (fl0 !== efl[t]) begin
            n_err++;
            $display("FAIL ff_flags[%0d]: got %b required %b", t, fl0, efl[t]);
         end
         nb = word_diffs(rx0);
         n_cmp++;
         if (nb !== 0) begin
            n_err++;
            $display("FAIL ff_words[%0d]: got %0d words, %0d bad; required 128 of ffffffff", t, rx0.size(), nb);
         end
      end
   endtask

   // 4-byte block: word timing, done timing, random CRC/end-bit errors.
   task automatic test_small();
      logic [15:0] c;
      logic        eb, corrupt;
      logic [7:0]  b;
      logic [3:0]  ef;
      for (int it = 0; it < 6; it++) begin
         set_ready(1'b0);
         if (it == 0) begin
            blk.delete();
            blk.push_back(8'h12); blk.push_back(8'h34);
            blk.push_back(8'h56); blk.push_back(8'h78);
            corrupt = 1'b0; eb = 1'b1;
         end else begin
            fill_rand(4);
            corrupt = 1'($urandom_range(0, 1));
            eb = 1'($urandom_range(0, 1));
         end
         build_exp();
         c = model_crc() ^ (corrupt ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
         ef = {corrupt, ~eb, 2'b00};
         arm(1);
         for (int i = 0; i < $urandom_range(0, 3); i++) begin strobe(1'b1); gap(); end
         strobe(1'b0); gap();
         for (int i = 0; i < 32; i++) begin
            b = blk[i / 8];
            strobe(b[7 - (i % 8)]);
            if (i == 30) begin
               @(negedge clk);
               n_cmp++;
               if (wv1 !== 1'b0) begin
                  n_err++;
                  $display("FAIL small_early_valid[%0d]: got %b required 0", it, wv1);
               end
            end
            if (i == 31) begin
               @(negedge clk);
               n_cmp++;
               if ({wv1, word1} !== {1'b1, expw[0]}) begin
                  n_err++;
                  $display("FAIL small_word[%0d]: got v=%b %h required v=1 %h", it, wv1, word1, expw[0]);
               end
            end
            gap();
         end
         for (int j = 15; j >= 0; j--) begin strobe(c[j]); gap(); end
         @(negedge clk);
         n_cmp++;
         if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL small_early_done[%0d]: got done=%b busy=%b required 0/1", it, done1, busy1);
         end
         strobe(eb);
         dat = 1'b1;
         @(negedge clk);
         n_cmp++;
         if ({done1, busy1, crce1, ende1, to1, ov1} !== {2'b10, ef}) begin
            n_err++;
            $display("FAIL small_done[%0d]: got done=%b busy=%b flags=%b required 1/0/%b",
                     it, done1, busy1, {crce1, ende1, to1, ov1}, ef);
         end
         set_ready(1'b1);
         repeat (3) @(posedge clk);
      end
   endtask

   task automatic test_timeout();
      set_ready(1'b1);
      repeat (3) @(posedge clk);
      #1;
      arm(0);
      for (int i = 1; i <= 8; i++) begin
         strobe(1'b1);
         @(negedge clk);
         if (i == 7) begin
            n_cmp++;
            if ({done0, busy0} !== 2'b01) begin
               n_err++;
               $display("FAIL timeout_early: got done=%b busy=%b required 0/1", done0, busy0);
            end
         end
         if (i == 8) begin
            n_cmp++;
            if ({done0, busy0, wv0, crce0, ende0, to0, ov0} !== 7'b1000010) begin
               n_err++;
               $display("FAIL timeout_done: got %b required 1000010", {done0, busy0, wv0, crce0, ende0, to0, ov0});
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({done0, to0} !== 2'b01) begin
         n_err++;
         $display("FAIL timeout_pulse: got done=%b to=%b required 0/1", done0, to0);
      end
   endtask

   // Overrun with a stalled consumer, then a fresh start keeps buffered words.
   task automatic test_back_to_back();
      logic [31:0] first2[$];
      int d, nb;
      set_ready(1'b0);
      fill_rand(512);
      build_exp();
      d = dn0;
      arm(0);
      send_frame(model_crc(), 1'b1, $urandom_range(0, 6));
      repeat (4) @(negedge clk);
      n_cmp++;
      if (dn0 - d !== 1 || fl0 !== 4'b0001) begin
         n_err++;
         $display("FAIL overrun_flags: got done=%0d flags=%b required 1/0001", dn0 - d, fl0);
      end
      first2.delete();
      first2.push_back(expw[0]);
      first2.push_back(expw[1]);
      arm(0);
      @(negedge clk);
      n_cmp++;
      if ({wv0, word0, crce0, ende0, to0, ov0} !== {1'b1, first2[0], 4'b0000}) begin
         n_err++;
         $display("FAIL restart_keeps_words: got v=%b %h flags=%b required v=1 %h 0000",
                  wv0, word0, {crce0, ende0, to0, ov0}, first2[0]);
      end
      set_ready(1'b1);
      rx0.delete();
      repeat (6) @(posedge clk);
      #1;
      expw = first2;
      nb = word_diffs(rx0);
      n_cmp++;
      if (nb !== 0) begin
         n_err++;
         $display("FAIL overrun_drain: got %0d words, %0d bad; required %h %h", rx0.size(), nb, first2[0], first2[1]);
      end
      rx0.delete();
      fill_rand(512);
      build_exp();
      d = dn0;
      send_frame(model_crc(), 1'b1, $urandom_range(0, 6));
      repeat (4) @(negedge clk);
      nb = word_diffs(rx0);
      n_cmp++;
      if (nb !== 0 || dn0 - d !== 1 || fl0 !== 4'b0000) begin
         n_err++;
         $display("FAIL second_block: got %0d words %0d bad done=%0d flags=%b required 128/0/1/0000",
                  rx0.size(), nb, dn0 - d, fl0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] b;
      int d, nb;
      set_ready(1'b0);
      fill_rand(512);
      d = dn0;
      arm(0);
      strobe(1'b0);
      for (int i = 0; i < 100; i++) begin
         b = blk[i / 8];
         strobe(b[7 - (i % 8)]);
         gap();
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy0, wv0} !== 2'b00 || dn0 !== d) begin
         n_err++;
         $display("FAIL abort_flush: got busy=%b valid=%b done=%0d required 0/0/0", busy0, wv0, dn0 - d);
      end
      start0 = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy0 !== 1'b0) begin
         n_err++;
         $display("FAIL abort_beats_start: got busy=%b required 0", busy0);
      end
      set_ready(1'b1);
      rx0.delete();
      fill_rand(512);
      build_exp();
      arm(0);
      send_frame(model_crc(), 1'b1, $urandom_range(0, 6));
      repeat (4) @(negedge clk);
      nb = word_diffs(rx0);
      n_cmp++;
      if (nb !== 0 || dn0 - d !== 1 || fl0 !== 4'b0000) begin
         n_err++;
         $display("FAIL after_abort: got %0d words %0d bad done=%0d flags=%b required 128/0/1/0000",
                  rx0.size(), nb, dn0 - d, fl0);
      end
   endtask

   task automatic test_mid_reset();
      set_ready(1'b0);
      fill_rand(4);
      arm(1);
      strobe(1'b0);
      for (int i = 0; i < 32; i++) strobe(1'($urandom_range(0, 1)));
      strobe(1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({word1, wv1, busy1, done1, crce1, ende1, to1, ov1} !== 39'd0) begin
         n_err++;
         $display("FAIL mid_reset: got %h required 0", {word1, wv1, busy1, done1, crce1, ende1, to1, ov1});
      end
   endtask

   initial begin
      test_reset();
      test_ff_block();
      test_small();
      test_timeout();
      test_back_to_back();
      test_abort();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/neosd_dat_rx.md
# neosd_dat_rx

SD DAT0 block-read receiver for the neosd controller, sitting beside the CMD engine and consuming the same divided SD bit strobe. Once armed by the control logic after a read command, it waits for the card's start bit and deserialises one data block MSB-first. It checks CRC16 and the end bit, then hands 32-bit words to the host-side DATA register path through a 2-entry buffer with a valid/ready handshake. On completion it reports a one-cycle done pulse with error flags.

## Interface
- BLOCK_BYTES, 512: data bytes per block; multiple of 4, range 4..2048.
- TIMEOUT, 1024: bit strobes allowed in WAIT_START before giving up; ≥1.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- bit_stb_i  in  1  one-cycle sample strobe, once per SD clock period; DAT0 is sampled only on cycles where it is 1.
- sd_dat0_i  in  1  DAT0 line, already synchronised.
- start_i  in  1  one-cycle arm request.
- abort_i  in  1  one-cycle abort.
- word_o  out  32  received data word; first wire byte in [31:24].
- word_valid_o  out  1  word_o holds a word.
- word_ready_i  in  1  consumer accepts word_o when valid & ready.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle completion pulse.
- crc_err_o, end_err_o, timeout_o, overrun_o  out  1 each  status flags, valid from done_o until the next accepted start_i.

## Operation
- Reset: FSM = IDLE; buffer emptied; all outputs 0, including word_o.
- States and transitions:
  - IDLE → WAIT_START on start_i. On entry: status flags clear, timeout counter = 0, CRC = 0x0000, bit and byte counters = 0. start_i while busy is ignored.
  - WAIT_START: on each bit_stb_i, if sd_dat0_i = 0 go to DATA. Otherwise increment the counter; when it reaches TIMEOUT, set timeout_o, pulse done_o, go to IDLE.
  - DATA: each bit_stb_i shifts sd_dat0_i into a 32-bit shift register (LSB in, MSB-first) and updates the CRC. After the 32nd bit of a word, the word is pushed into the buffer. If the buffer already holds 2 words, the word is dropped, overrun_o is set (sticky) and reception continues. After BLOCK_BYTES*8 bits, go to CRC.
  - CRC: shift 16 bits MSB-first into a receive CRC register, then go to END.
  - END: on the next bit_stb_i, set end_err_o if sd_dat0_i = 0. Set crc_err_o if the received CRC ≠ the computed CRC. Pulse done_o and go to IDLE.
- CRC16-CCITT: polynomial x^16+x^12+x^5+1, initial value 0, computed over data bits only, serial form. Feedback = crc[15]^bit; the shift feeds crc[0], and bits 5 and 12 are XORed with the feedback.
- abort_i in any state: go to IDLE next cycle, no done_o, flags unchanged, buffer flushed. abort_i together with start_i: abort wins and the block stays in IDLE.
- Buffer is 2-entry FIFO order, pop on valid & ready. Push and pop in the same cycle are both applied; occupancy is unchanged and nothing is dropped.
- Words left in the buffer after done_o remain readable. The next start_i does not flush them; only abort_i or rst_i does.

## Timing
- The DAT0 sample and every state/counter update happen on the clk_i edge where bit_stb_i = 1; nothing advances between strobes.
- word_valid_o rises in the cycle after the strobe that completes the word.
- word_o is registered with no combinational path from word_ready_i. The next word appears in the cycle after a pop.
- done_o asserts in the cycle after the END strobe (or the timeout strobe). Flags are valid in the same cycle and held afterwards.
- Start bit to done: 1 + BLOCK_BYTES*8 + 16 + 1 strobes.
- Reset mid-block wins over all inputs; state, flags and buffer return to reset values on the next edge.

## Test plan
- BLOCK_BYTES = 512, card sends start bit, 512×0xFF, CRC 0x7FA1, end bit 1, consumer always ready → 128 words of 0xFFFFFFFF, done_o once, all flags 0.
- Same block with CRC 0x7FA0 → crc_err_o = 1, end_err_o = 0. Separately, end bit 0 with correct CRC → end_err_o = 1, crc_err_o = 0.
- BLOCK_BYTES = 4, bytes 0x12, 0x34, 0x56, 0x78 → word_o = 0x12345678, CRC check follows the serial algorithm above, done_o after 50 strobes from the start bit.
- DAT0 held 1 and TIMEOUT = 8 → done_o in the cycle after the 8th strobe, timeout_o = 1, no word_valid_o.
- BLOCK_BYTES = 16, word_ready_i held 0 → words 1–2 buffered, words 3–4 dropped, overrun_o = 1. Then raising ready → exactly 2 words drained in order.
- abort_i mid-DATA, then start_i two cycles later with a correct block → no done_o for the aborted transfer, buffer empty after abort, second transfer completes clean.
